// File: rtl/flasher_segment_sequencer.sv
// flasher_segment_sequencer
// Steps a lit-LED level through a table of target-level segments, with an
// optional flick-driven kickback to the previous segment at segment ends.
// The table can be rewritten while idle; reset restores the standard
// bound-flasher pattern.
module flasher_segment_sequencer #(
  parameter int NUM_SEG   = 6,
  parameter int MAX_LEVEL = 16,
  parameter int TICK_DIV  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flick,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [4:0] cfg_target,
  input  logic       cfg_kick,
  output logic [4:0] level,
  output logic [2:0] seg_idx,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] MAX_LVL   = 5'(MAX_LEVEL);
  localparam logic [3:0] NUM_SEG_W = 4'(NUM_SEG);
  localparam logic [2:0] LAST_SEG  = 3'(NUM_SEG - 1);
  localparam int         PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Power-up pattern: up to full, down to 5, up to 10, down to 0, up to 5,
  // down to 0. Segments 1 and 3 allow a flick kickback.
  function automatic logic [4:0] default_target(input int i);
    case (i)
      0:       default_target = MAX_LVL;
      1:       default_target = 5'd5;
      2:       default_target = 5'd10;
      4:       default_target = 5'd5;
      default: default_target = 5'd0;
    endcase
  endfunction

  function automatic logic default_kick(input int i);
    default_kick = (i == 1) || (i == 3);
  endfunction

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;
  logic [4:0]    seg_target [8];
  logic          seg_kick   [8];
  logic          write_ok;
  logic [4:0]    wr_target;
  logic [7:0]    entry_we;
  logic [4:0]    cur_target;
  logic          cur_kick;

  // A write is legal only while idle and only into an entry that exists.
  assign write_ok  = cfg_we && !busy && ({1'b0, cfg_addr} < NUM_SEG_W);
  assign wr_target = (cfg_target > MAX_LVL) ? MAX_LVL : cfg_target;
  assign tick      = (presc == PRESC_LAST);

  // Segment data is sampled only on ticks, so a same-cycle write+start
  // still uses the freshly written entry.
  assign cur_target = seg_target[seg_idx];
  assign cur_kick   = seg_kick[seg_idx];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_entry_we
      assign entry_we[gi] = write_ok && (cfg_addr == 3'(gi));
    end
  endgenerate

  // Segment table: reset restores the default pattern, accepted writes update one entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        seg_target[i] <= default_target(i);
        seg_kick[i]   <= default_kick(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (entry_we[i]) begin
          seg_target[i] <= wr_target;
          seg_kick[i]   <= cfg_kick;
        end
      end
    end
  end

  // Sequencer FSM with registered outputs and tick prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      level   <= 5'd0;
      seg_idx <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      presc   <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= cfg_we && !write_ok;
      case (state)
        IDLE: begin
          presc <= '0;
          if (flick) begin
            state   <= RUN;
            seg_idx <= 3'd0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            presc <= '0;
            if (level < cur_target) begin
              if (level < MAX_LVL) level <= level + 5'd1;
            end else if (level > cur_target) begin
              if (level != 5'd0) level <= level - 5'd1;
            end else begin
              // Completion tick: kickback, advance, or finish the run.
              if (cur_kick && flick) begin
                if (seg_idx != 3'd0) seg_idx <= seg_idx - 3'd1;
              end else if (seg_idx < LAST_SEG) begin
                seg_idx <= seg_idx + 3'd1;
              end else begin
                done    <= 1'b1;
                state   <= IDLE;
                busy    <= 1'b0;
                seg_idx <= 3'd0;
              end
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flasher_segment_sequencer.sv
// Directed testbench for flasher_segment_sequencer: default pattern, kickback,
// table writes and rejections, async reset mid-run, and a TICK_DIV=4 instance.
module tb_flasher_segment_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       flick = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = 3'd0;
  logic [4:0] cfg_target = 5'd0;
  logic       cfg_kick = 1'b0;
  logic [4:0] level;
  logic [2:0] seg_idx;
  logic       busy, done, cfg_err;

  logic       flick4 = 1'b0;
  logic       we4 = 1'b0;
  logic [2:0] addr4 = 3'd0;
  logic [4:0] target4 = 5'd0;
  logic       kick4 = 1'b0;
  logic [4:0] level4;
  logic [2:0] seg_idx4;
  logic       busy4, done4, cfg_err4;

  flasher_segment_sequencer #(.NUM_SEG(6), .MAX_LEVEL(16), .TICK_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .flick(flick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_target(cfg_target), .cfg_kick(cfg_kick), .level(level), .seg_idx(seg_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  flasher_segment_sequencer #(.NUM_SEG(6), .MAX_LEVEL(16), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .flick(flick4), .cfg_we(we4), .cfg_addr(addr4),
    .cfg_target(target4), .cfg_kick(kick4), .level(level4), .seg_idx(seg_idx4),
    .busy(busy4), .done(done4), .cfg_err(cfg_err4)
  );

  int vectors = 0;
  int miscompares = 0;

  // Hand-computed checkpoints of the default pattern, edges counted after start.
  int d_k    [13] = '{16, 17, 28, 29, 34, 35, 45, 46, 51, 52, 57, 58, 59};
  int d_lvl  [13] = '{16, 16,  5,  5, 10, 10,  0,  0,  5,  5,  0,  0,  0};
  int d_seg  [13] = '{ 0,  1,  1,  2,  2,  3,  3,  4,  4,  5,  5,  0,  0};
  int d_busy [13] = '{ 1,  1,  1,  1,  1,  1,  1,  1,  1,  1,  1,  0,  0};
  int d_done [13] = '{ 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a run from level 0 and follow the default table to completion.
  task automatic run_default(input string name);
    int ndone;
    flick = 1'b1;
    step();
    check({name, "_start_busy"}, 32'(busy), 1);
    check({name, "_start_seg"}, 32'(seg_idx), 0);
    flick = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 59; k++) begin
      step();
      if (done === 1'b1) ndone++;
      for (int j = 0; j < 13; j++) begin
        if (d_k[j] == k) begin
          check($sformatf("%s_lvl_e%0d", name, k), 32'(level), 32'(d_lvl[j]));
          check($sformatf("%s_seg_e%0d", name, k), 32'(seg_idx), 32'(d_seg[j]));
          check($sformatf("%s_busy_e%0d", name, k), 32'(busy), 32'(d_busy[j]));
          check($sformatf("%s_done_e%0d", name, k), 32'(done), 32'(d_done[j]));
        end
      end
    end
    check({name, "_done_count"}, 32'(ndone), 1);
  endtask

  initial begin
    // ---- Reset values ----
    #2 rst = 1'b1;
    step();
    step();
    check("rst_level", 32'(level), 0);
    check("rst_seg", 32'(seg_idx), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_level4", 32'(level4), 0);
    @(negedge clk) rst = 1'b0;
    step();
    check("idle_busy", 32'(busy), 0);

    // ---- Default pattern, single flick ----
    run_default("dflt");

    // ---- Kickback: flick held through segment-1 completion ----
    flick = 1'b1;
    step();
    check("kick_start_busy", 32'(busy), 1);
    for (int k = 1; k <= 83; k++) begin
      step();
      if (k == 17) check("kick_seg_e17", 32'(seg_idx), 1);
      if (k == 29) begin
        check("kick_seg_e29", 32'(seg_idx), 0);
        check("kick_lvl_e29", 32'(level), 5);
        flick = 1'b0;
      end
      if (k == 40) check("kick_lvl_e40", 32'(level), 16);
      if (k == 41) check("kick_seg_e41", 32'(seg_idx), 1);
      if (k == 52) check("kick_lvl_e52", 32'(level), 5);
      if (k == 53) check("kick_seg_e53", 32'(seg_idx), 2);
      if (k == 81) check("kick_done_e81", 32'(done), 0);
      if (k == 82) begin
        check("kick_done_e82", 32'(done), 1);
        check("kick_busy_e82", 32'(busy), 0);
        check("kick_seg_e82", 32'(seg_idx), 0);
      end
    end

    // ---- Table writes while idle, rejected writes ----
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_target = 5'd12; cfg_kick = 1'b0;
    step();
    check("wr0_cfg_err", 32'(cfg_err), 0);
    cfg_addr = 3'd2; cfg_target = 5'd31;
    step();
    check("wr2_cfg_err", 32'(cfg_err), 0);
    cfg_addr = 3'd7; cfg_target = 5'd1;
    step();
    check("wr7_cfg_err", 32'(cfg_err), 1);
    cfg_we = 1'b0;
    flick = 1'b1;
    step();
    check("wr_start_cfg_err", 32'(cfg_err), 0);
    check("wr_start_busy", 32'(busy), 1);
    flick = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (k == 4) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_target = 5'd3;
      end
      if (k == 5) begin
        check("run_we_cfg_err", 32'(cfg_err), 1);
        cfg_we = 1'b0;
      end
      if (k == 6) check("run_we_cfg_err_clr", 32'(cfg_err), 0);
      if (k == 12) check("wr_lvl_e12", 32'(level), 12);
      if (k == 13) begin
        check("wr_lvl_e13", 32'(level), 12);
        check("wr_seg_e13", 32'(seg_idx), 1);
      end
      if (k == 20) check("wr_lvl_e20", 32'(level), 5);
      if (k == 30) check("wr_lvl_e30", 32'(level), 14);
      if (k == 32) check("clamp_lvl_e32", 32'(level), 16);
      if (k == 33) begin
        check("clamp_lvl_e33", 32'(level), 16);
        check("clamp_seg_e33", 32'(seg_idx), 3);
      end
      if (k == 34) check("wr_lvl_e34", 32'(level), 15);
    end

    // ---- Asynchronous reset mid-run ----
    #1 rst = 1'b1;
    #1;
    check("arst_level", 32'(level), 0);
    check("arst_seg", 32'(seg_idx), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_cfg_err", 32'(cfg_err), 0);
    @(negedge clk) rst = 1'b0;
    step();
    check("post_rst_idle", 32'(busy), 0);
    run_default("post_rst");

    // ---- TICK_DIV = 4 ----
    flick4 = 1'b1;
    step();
    check("td4_busy", 32'(busy4), 1);
    check("td4_lvl_e0", 32'(level4), 0);
    flick4 = 1'b0;
    repeat (3) step();
    check("td4_lvl_e3", 32'(level4), 0);
    step();
    check("td4_lvl_e4", 32'(level4), 1);
    repeat (3) step();
    check("td4_lvl_e7", 32'(level4), 1);
    step();
    check("td4_lvl_e8", 32'(level4), 2);
    repeat (4) step();
    check("td4_lvl_e12", 32'(level4), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
